// File: rtl/instr_prefetch_if.sv
// Memory-read and instruction-stream signals of the prefetch unit.
// The master modport is the prefetcher; the slave modport is memory plus decoder.
interface instr_prefetch_if #(
    parameter int unsigned SIZE = 16
);
    logic [SIZE-1:0] MAB_out;
    logic            mem_req;
    logic            mem_ack;
    logic [SIZE-1:0] MDB_in;
    logic [SIZE-1:0] instr_out;
    logic [SIZE-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_rdy;

    modport master (
        output MAB_out,
        output mem_req,
        input  mem_ack,
        input  MDB_in,
        output instr_out,
        output instr_pc,
        output instr_valid,
        input  instr_rdy
    );

    modport slave (
        input  MAB_out,
        input  mem_req,
        output mem_ack,
        output MDB_in,
        input  instr_out,
        input  instr_pc,
        input  instr_valid,
        output instr_rdy
    );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: owns the fetch PC, issues word reads and queues words with addresses.
// Optional flushed-word counter output drop_cnt when PREFETCH_DROP_CNT_EN is defined.
module instr_prefetch #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SIZE-1:0]          RST_VEC,
    input  logic                     br_en,
    input  logic [SIZE-1:0]          br_target,
    output logic [$clog2(DEPTH):0]   q_count,
`ifdef PREFETCH_DROP_CNT_EN
    output logic [15:0]              drop_cnt,
`endif
    instr_prefetch_if.master         bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0]   DepthCnt = CW'(DEPTH);
    localparam logic [SIZE-1:0] PcMask   = ~SIZE'(1);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e          state_q;
    logic [SIZE-1:0] fetch_pc_q;
    logic [SIZE-1:0] mab_q;
    logic            mem_req_q;

    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [SIZE-1:0] data_q [DEPTH];
    logic [SIZE-1:0] addr_q [DEPTH];

    logic            push, pop;
    logic [SIZE-1:0] pc_inc, br_pc, rst_pc;

    assign pc_inc = fetch_pc_q + SIZE'(2);
    assign br_pc  = br_target & PcMask;
    assign rst_pc = RST_VEC & PcMask;

    // A redirect overrides both queue operations in the same cycle.
    assign push = (state_q == StReq) && bus.mem_ack && !br_en;
    assign pop  = (count_q != '0) && bus.instr_rdy && !br_en;

    always_comb begin
        count_d = count_q;
        if (br_en) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Fetch FSM; the outstanding request reserves a slot, so issue only while count_d < DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= rst_pc;
            mab_q      <= rst_pc;
            mem_req_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (br_en) begin
                        fetch_pc_q <= br_pc;
                    end else if (count_q < DepthCnt) begin
                        state_q   <= StReq;
                        mem_req_q <= 1'b1;
                        mab_q     <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (br_en) begin
                        fetch_pc_q <= br_pc;
                        if (bus.mem_ack) begin
                            state_q   <= StIdle;
                            mem_req_q <= 1'b0;
                        end else begin
                            // Old request stays on the bus until memory completes it.
                            state_q <= StDrop;
                        end
                    end else if (bus.mem_ack) begin
                        fetch_pc_q <= pc_inc;
                        if (count_d < DepthCnt) begin
                            mab_q <= pc_inc;
                        end else begin
                            state_q   <= StIdle;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                StDrop: begin
                    if (br_en) begin
                        fetch_pc_q <= br_pc;
                    end
                    if (bus.mem_ack) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (br_en) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) begin
                    data_q[wr_ptr_q] <= bus.MDB_in;
                    addr_q[wr_ptr_q] <= fetch_pc_q;
                    wr_ptr_q         <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
        end
    end

`ifdef PREFETCH_DROP_CNT_EN
    logic [15:0]   drop_cnt_q;
    logic [16:0]   drop_sum;
    logic [CW-1:0] flushed;
    logic          discard;

    // Discarded words: flushed queue entries plus any read data thrown away.
    always_comb begin
        flushed  = br_en ? count_q : '0;
        discard  = bus.mem_ack && (((state_q == StReq) && br_en) || (state_q == StDrop));
        drop_sum = {1'b0, drop_cnt_q} + 17'(flushed) + 17'(discard);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign bus.MAB_out     = mab_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.instr_out   = data_q[rd_ptr_q];
    assign bus.instr_pc    = addr_q[rd_ptr_q];
    assign bus.instr_valid = (count_q != '0);
    assign q_count         = count_q;

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: directed fetch, drain, redirect, wrap and reset scenarios.
// Build with PREFETCH_DROP_CNT_EN defined to also check the drop counter.
module tb_instr_prefetch;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rst_vec = 16'hF800;
    logic        br_en = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [2:0]  q_count;
`ifdef PREFETCH_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int     checks = 0;
    int     errors = 0;
    int     wait_states = 0;
    int     wcnt = 0;
    entry_t exp_q[$];

    instr_prefetch_if #(.SIZE(SIZE)) bus ();

    instr_prefetch #(
        .SIZE (SIZE),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RST_VEC  (rst_vec),
        .br_en    (br_en),
        .br_target(br_target),
        .q_count  (q_count),
`ifdef PREFETCH_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] pc);
        exp_q.push_back({mem_word(pc), pc});
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_empty(input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            at_neg();
            n++;
        end
        chk("sb_drained", exp_q.size(), 0);
    endtask

    task automatic wait_req(input logic val, input int lim);
        int n = 0;
        while (bus.mem_req !== val && n < lim) begin
            at_neg();
            n++;
        end
        chk("wait_req", bus.mem_req, val);
    endtask

    // Memory: acks after wait_states idle cycles of a held request.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end else if (bus.mem_req) begin
                if (wcnt >= wait_states) begin
                    bus.mem_ack = 1'b1;
                    bus.MDB_in  = mem_word(bus.MAB_out);
                    wcnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: every pop the DUT will take at the next edge is matched against the queue head.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.instr_valid && bus.instr_rdy && !br_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %0h expected no word", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", bus.instr_pc, e.pc);
                    chk("pop_data", bus.instr_out, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        bus.mem_ack   = 1'b0;
        bus.MDB_in    = 16'h0000;
        bus.instr_rdy = 1'b0;
        repeat (3) at_neg();

        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mab", bus.MAB_out, 16'hF800);
        chk("rst_q_count", q_count, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_instr_out", bus.instr_out, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
`ifdef PREFETCH_DROP_CNT_EN
        chk("rst_drop_cnt", drop_cnt, 0);
`endif

        // Fill with ack every cycle and no consumer.
        at_pos();
        rst = 1'b0;
        at_neg();
        chk("first_req_delay", bus.mem_req, 0);
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("fill_req", bus.mem_req, 1);
            chk("fill_mab", bus.MAB_out, 16'hF800 + 16'(2 * k));
        end
        at_neg();
        chk("full_req_off", bus.mem_req, 0);
        chk("full_count", q_count, 4);
        chk("full_valid", bus.instr_valid, 1);

        // Drain with consumer always ready.
        for (int i = 0; i < 12; i++) expect_word(16'hF800 + 16'(2 * i));
        at_pos();
        bus.instr_rdy = 1'b1;
        repeat (6) at_neg();
        for (int i = 0; i < 3; i++) begin
            chk("steady_count", q_count, 2);
            at_neg();
        end
        wait_empty(40);

        // Redirect from a full idle queue, then redirect during a wait-stated read.
        at_pos();
        bus.instr_rdy = 1'b0;
        wait_states = 3;
        wait_req(1'b0, 60);
        chk("full_before_br", q_count, 4);
        at_pos();
        br_en = 1'b1;
        br_target = 16'h1000;
        at_pos();
        br_en = 1'b0;
        at_neg();
        chk("br_idle_valid", bus.instr_valid, 0);
        chk("br_idle_count", q_count, 0);
        chk("br_idle_req", bus.mem_req, 0);
`ifdef PREFETCH_DROP_CNT_EN
        chk("drop_cnt_flush4", drop_cnt, 4);
`endif
        at_neg();
        chk("br_target_req", bus.mem_req, 1);
        chk("br_target_mab", bus.MAB_out, 16'h1000);
        at_pos();
        br_en = 1'b1;
        br_target = 16'hC001;
        bus.instr_rdy = 1'b1;
        expect_word(16'hC000);
        expect_word(16'hC002);
        at_pos();
        br_en = 1'b0;
        at_neg();
        chk("drop_hold_req", bus.mem_req, 1);
        chk("drop_hold_mab", bus.MAB_out, 16'h1000);
        at_neg();
        at_neg();
        chk("drop_done_req", bus.mem_req, 0);
        chk("drop_done_count", q_count, 0);
`ifdef PREFETCH_DROP_CNT_EN
        chk("drop_cnt_drop_ack", drop_cnt, 5);
`endif
        at_neg();
        chk("drop_next_req", bus.mem_req, 1);
        chk("drop_next_mab", bus.MAB_out, 16'hC000);
        wait_empty(60);

        // Redirect coinciding with an ack while two words are queued.
        at_pos();
        bus.instr_rdy = 1'b0;
        wait_states = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            at_pos();
            if (q_count == 3'd2 && bus.mem_req) begin
                found = 1;
                break;
            end
        end
        chk("found_two_queued", found, 1);
        br_en = 1'b1;
        br_target = 16'h2000;
        at_pos();
        br_en = 1'b0;
        at_neg();
        chk("br_ack_count", q_count, 0);
        chk("br_ack_valid", bus.instr_valid, 0);
        chk("br_ack_req", bus.mem_req, 0);
`ifdef PREFETCH_DROP_CNT_EN
        chk("drop_cnt_br_ack", drop_cnt, 8);
`endif
        at_neg();
        chk("br_ack_next_req", bus.mem_req, 1);
        chk("br_ack_next_mab", bus.MAB_out, 16'h2000);

        // Fetch address wrap.
        at_pos();
        br_en = 1'b1;
        br_target = 16'hFFFE;
        bus.instr_rdy = 1'b1;
        expect_word(16'hFFFE);
        expect_word(16'h0000);
        expect_word(16'h0002);
        at_pos();
        br_en = 1'b0;
        at_neg();
        chk("wrap_flush_valid", bus.instr_valid, 0);
        at_neg();
        chk("wrap_mab_top", bus.MAB_out, 16'hFFFE);
        chk("wrap_req", bus.mem_req, 1);
        at_neg();
        chk("wrap_mab_zero", bus.MAB_out, 16'h0000);
        wait_empty(40);

        // Asynchronous reset in the middle of a pending read.
        at_pos();
        bus.instr_rdy = 1'b0;
        wait_states = 3;
        wait_req(1'b1, 20);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_req", bus.mem_req, 0);
        chk("async_rst_count", q_count, 0);
        chk("async_rst_valid", bus.instr_valid, 0);
        chk("async_rst_mab", bus.MAB_out, 16'hF800);
`ifdef PREFETCH_DROP_CNT_EN
        chk("async_rst_drop_cnt", drop_cnt, 0);
`endif
        at_pos();
        at_pos();
        rst = 1'b0;
        wait_states = 0;
        bus.instr_rdy = 1'b1;
        expect_word(16'hF800);
        expect_word(16'hF802);
        at_neg();
        chk("refetch_delay", bus.mem_req, 0);
        at_neg();
        chk("refetch_req", bus.mem_req, 1);
        chk("refetch_mab", bus.MAB_out, 16'hF800);
        wait_empty(40);
        at_pos();
        bus.instr_rdy = 1'b0;
        repeat (3) at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
